// File: rtl/ram_arbiter.sv
// Two-master arbiter for the single data RAM: CPU (requester 0) and debug/loader (requester 1).
// Owner FSM with bounded-burst fairness; read data is routed back via a tag pipeline.
module ram_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              ram_wr_sig,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wr_data,
    input  logic [DATA_W-1:0] ram_rd_data
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    localparam logic [3:0] BurstMax = 4'(BURST_MAX);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  cnt_inc;
    logic        grant0, grant1;
    logic        rd_push;
    logic [RD_LAT-1:0] tag_v_q, tag_id_q;
    logic        tag_out_v, tag_out_id;

    assign cnt_inc = (cnt_q < BurstMax) ? cnt_q + 4'd1 : cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant0  = 1'b0;
        grant1  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (req0) begin
                    grant0  = 1'b1;
                    state_d = StOwn0;
                    cnt_d   = 4'd1;
                end else if (req1) begin
                    grant1  = 1'b1;
                    state_d = StOwn1;
                    cnt_d   = 4'd1;
                end
            end
            StOwn0: begin
                // Owner keeps the RAM until its burst is spent while the other waits.
                if (req0 && (!req1 || cnt_q < BurstMax)) begin
                    grant0 = 1'b1;
                    cnt_d  = cnt_inc;
                end else if (req1) begin
                    grant1  = 1'b1;
                    state_d = StOwn1;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end
            end
            StOwn1: begin
                if (req1 && (!req0 || cnt_q < BurstMax)) begin
                    grant1 = 1'b1;
                    cnt_d  = cnt_inc;
                end else if (req0) begin
                    grant0  = 1'b1;
                    state_d = StOwn0;
                    cnt_d   = 4'd1;
                end else begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Grants are suppressed while reset is asserted so the RAM sees no access.
    assign gnt0 = grant0 & reset_n;
    assign gnt1 = grant1 & reset_n;

    always_comb begin
        ram_wr_sig  = 1'b0;
        ram_addr    = '0;
        ram_wr_data = '0;
        if (gnt0) begin
            ram_wr_sig  = we0;
            ram_addr    = addr0;
            ram_wr_data = wdata0;
        end else if (gnt1) begin
            ram_wr_sig  = we1;
            ram_addr    = addr1;
            ram_wr_data = wdata1;
        end
    end

    assign rd_push    = (gnt0 & ~we0) | (gnt1 & ~we1);
    assign tag_out_v  = tag_v_q[RD_LAT-1];
    assign tag_out_id = tag_id_q[RD_LAT-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_v_q  <= '0;
            tag_id_q <= '0;
        end else begin
            tag_v_q[0]  <= rd_push;
            tag_id_q[0] <= gnt1;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v_q[i]  <= tag_v_q[i-1];
                tag_id_q[i] <= tag_id_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
        end else begin
            rvalid0 <= tag_out_v & ~tag_out_id;
            rvalid1 <= tag_out_v & tag_out_id;
            if (tag_out_v && !tag_out_id) rdata0 <= ram_rd_data;
            if (tag_out_v && tag_out_id)  rdata1 <= ram_rd_data;
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a one-cycle-latency RAM model.
module tb_ram_arbiter;

    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 32;
    localparam int unsigned LAT = 1;
    localparam int unsigned BM  = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, we0, gnt0, rvalid0;
    logic          req1, we1, gnt1, rvalid1;
    logic [AW-1:0] addr0, addr1, ram_addr;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1, ram_wr_data, ram_rd_data;
    logic          ram_wr_sig;

    logic [DW-1:0] mem [256];
    logic [DW-1:0] rd_q;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT), .BURST_MAX(BM)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .ram_wr_sig(ram_wr_sig), .ram_addr(ram_addr),
        .ram_wr_data(ram_wr_data), .ram_rd_data(ram_rd_data)
    );

    // Synchronous RAM: write at the edge, read data valid one cycle after the address.
    always @(posedge clk) begin
        if (ram_wr_sig) mem[ram_addr[7:0]] <= ram_wr_data;
        rd_q <= mem[ram_addr[7:0]];
    end
    assign ram_rd_data = rd_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    int  exp1 [12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    bit  got;

    initial begin
        reset_n = 1'b1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h10; wdata0 = 32'hDEADBEEF;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h10; wdata1 = 32'h0;
        #2 reset_n = 1'b0;
        tick(); tick(); mid();
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_gnt1", 32'(gnt1), 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_rvalid1", 32'(rvalid1), 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);
        chk("rst_wr_sig", 32'(ram_wr_sig), 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_wr_data", ram_wr_data, 0);

        // First cycle out of reset: requester 0 wins, writes 0x10.
        tick(); reset_n = 1'b1;
        mid();
        chk("first_gnt0", 32'(gnt0), 1);
        chk("first_gnt1", 32'(gnt1), 0);
        chk("wr_sig", 32'(ram_wr_sig), 1);
        chk("wr_addr", ram_addr, 32'h10);
        chk("wr_data", ram_wr_data, 32'hDEADBEEF);

        // Requester 1 reads back the same address on the next grant.
        tick(); req0 = 1'b0;
        mid();
        chk("raw_gnt1", 32'(gnt1), 1);
        chk("raw_gnt0", 32'(gnt0), 0);
        chk("raw_rd_sig", 32'(ram_wr_sig), 0);
        chk("raw_rd_addr", ram_addr, 32'h10);
        tick(); req1 = 1'b0;
        mid();
        chk("raw_early_rvalid1", 32'(rvalid1), 0);
        chk("idle_addr", ram_addr, 0);
        tick(); mid();
        chk("raw_rvalid1", 32'(rvalid1), 1);
        chk("raw_rdata1", rdata1, 32'hDEADBEEF);
        chk("raw_rvalid0", 32'(rvalid0), 0);
        tick(); mid();
        chk("raw_rvalid1_drop", 32'(rvalid1), 0);

        // Both requesting writes for 12 cycles: bursts of BURST_MAX.
        tick();
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h40; wdata0 = 32'h1;
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'h44; wdata1 = 32'h2;
        for (int i = 0; i < 12; i++) begin
            mid();
            chk($sformatf("fair_gnt1_%0d", i), 32'(gnt1), 32'(exp1[i]));
            chk($sformatf("fair_gnt0_%0d", i), 32'(gnt0), 32'(1 - exp1[i]));
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        mid();
        chk("fair_idle", 32'(gnt0 | gnt1), 0);
        tick();

        // Requester 1 alone streams, then requester 0 must get in within a burst.
        req1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            mid();
            chk($sformatf("solo_gnt1_%0d", i), 32'(gnt1), 1);
            tick();
        end
        req0 = 1'b1;
        got = 1'b0;
        for (int i = 0; i < int'(BM) && !got; i++) begin
            mid();
            if (gnt0) got = 1'b1;
            else tick();
        end
        chk("gnt0_within_burst", 32'(got), 1);
        tick(); req0 = 1'b0; req1 = 1'b0;
        mid(); tick();

        // Preload 0x20 = 0x11, 0x24 = 0x22.
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h20; wdata0 = 32'h11;
        mid(); chk("pre_gnt0_a", 32'(gnt0), 1);
        tick(); addr0 = 32'h24; wdata0 = 32'h22;
        mid(); chk("pre_gnt0_b", 32'(gnt0), 1);
        tick(); req0 = 1'b0;
        mid(); tick();

        // Interleaved reads on consecutive cycles.
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        mid(); chk("il_gnt0", 32'(gnt0), 1);
        tick(); req0 = 1'b0;
        req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24;
        mid(); chk("il_gnt1", 32'(gnt1), 1);
        tick(); req1 = 1'b0;
        mid();
        chk("il_rvalid0", 32'(rvalid0), 1);
        chk("il_rdata0", rdata0, 32'h11);
        chk("il_rvalid1_early", 32'(rvalid1), 0);
        tick(); mid();
        chk("il_rvalid1", 32'(rvalid1), 1);
        chk("il_rdata1", rdata1, 32'h22);
        chk("il_rvalid0_drop", 32'(rvalid0), 0);
        chk("il_rdata0_hold", rdata0, 32'h11);
        tick(); mid();
        chk("il_rvalid1_drop", 32'(rvalid1), 0);

        // Reset pulse right after a read grant discards the in-flight tag.
        tick(); req0 = 1'b1; we0 = 1'b0; addr0 = 32'h20;
        mid(); chk("mr_gnt0", 32'(gnt0), 1);
        tick(); req0 = 1'b0; reset_n = 1'b0;
        mid(); reset_n = 1'b1;
        chk("mr_rvalid0_rst", 32'(rvalid0), 0);
        for (int i = 0; i < 3; i++) begin
            tick(); mid();
            chk($sformatf("mr_rvalid0_%0d", i), 32'(rvalid0), 0);
            chk($sformatf("mr_rvalid1_%0d", i), 32'(rvalid1), 0);
        end
        chk("mr_rdata0_cleared", rdata0, 0);
        tick(); req1 = 1'b1; we1 = 1'b0; addr1 = 32'h24;
        mid(); chk("mr_next_gnt1", 32'(gnt1), 1);
        tick(); req1 = 1'b0;
        tick(); mid();
        chk("mr_next_rvalid1", 32'(rvalid1), 1);
        chk("mr_next_rdata1", rdata1, 32'h22);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
